// File: rtl/eth_udp_pkg.sv
// Shared definitions for the 128-bit Ethernet/IPv4/UDP payload extractor.
// Holds header byte offsets, protocol constants, the parser state type and
// small byte/keep helper functions.
package eth_udp_pkg;

  // Byte offsets from the start of the Ethernet frame
  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_PROTO     = 23;
  localparam int OFF_DPORT     = 36;
  localparam int OFF_ULEN      = 38;
  localparam int HDR_BYTES     = 42;

  // Payload begins at this byte lane of header word 2; the lanes above it
  // are carried over into the next output beat.
  localparam int PAY_BYTE   = HDR_BYTES % 16;
  localparam int HOLD_BYTES = 16 - PAY_BYTE;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    HDR2,
    PAYLOAD,
    FLUSH,
    DISCARD
  } state_t;

  // Byte of a 16-byte word selected by its absolute frame offset
  function automatic logic [7:0] get_byte(input logic [127:0] w, input int off);
    return w[8*(off%16) +: 8];
  endfunction

  // Contiguous low-aligned byte mask for count bytes (0..16)
  function automatic logic [15:0] keep_mask(input logic [4:0] count);
    logic [16:0] full_s;
    full_s = (17'd1 << count) - 17'd1;
    return full_s[15:0];
  endfunction

endpackage

// File: rtl/eth_udp_hdr_match.sv
// Combinational header field extraction and filter decision.
// Ports:
//   tdata        current input word (treated as word 0, 1 or 2 by the caller)
//   ethertype_q  ethertype latched from word 0
//   ver_ihl_q    IPv4 version/IHL latched from word 0
//   proto_q      IP protocol latched from word 1
//   cfg_udp_port accepted UDP destination port
//   ethertype    ethertype field of tdata viewed as word 0
//   ver_ihl      version/IHL field of tdata viewed as word 0
//   proto        protocol field of tdata viewed as word 1
//   pass         frame passes the filter when tdata is word 2
//   rem          UDP payload byte count (udp_len - 8) when tdata is word 2
module eth_udp_hdr_match
  import eth_udp_pkg::*;
(
  input  logic [127:0] tdata,
  input  logic [15:0]  ethertype_q,
  input  logic [7:0]   ver_ihl_q,
  input  logic [7:0]   proto_q,
  input  logic [15:0]  cfg_udp_port,
  output logic [15:0]  ethertype,
  output logic [7:0]   ver_ihl,
  output logic [7:0]   proto,
  output logic         pass,
  output logic [15:0]  rem
);

  logic [15:0] dport_s;
  logic [15:0] ulen_s;

  // Big-endian field extraction and the filter decision on word 2
  always_comb begin
    ethertype = {get_byte(tdata, OFF_ETHERTYPE), get_byte(tdata, OFF_ETHERTYPE + 1)};
    ver_ihl   = get_byte(tdata, OFF_VER_IHL);
    proto     = get_byte(tdata, OFF_PROTO);
    dport_s   = {get_byte(tdata, OFF_DPORT), get_byte(tdata, OFF_DPORT + 1)};
    ulen_s    = {get_byte(tdata, OFF_ULEN), get_byte(tdata, OFF_ULEN + 1)};
    pass      = (ethertype_q == ETHERTYPE_IPV4) && (ver_ihl_q == IPV4_VER_IHL) &&
                (proto_q == IP_PROTO_UDP) && (dport_s == cfg_udp_port) &&
                (ulen_s >= 16'd9);
    rem       = ulen_s - 16'd8;
  end

endmodule

// File: rtl/eth_udp_payload_extractor_128b.sv
// Extracts the UDP payload from FCS-stripped 128-bit Ethernet frames.
// Filters on IPv4/UDP/destination port, realigns the payload to byte 0,
// trims it to the UDP length and flags truncated frames in m_axis_tuser.
// Optional statistics counters are built when ETH_UDP_EXTRACTOR_STATS_EN
// is defined; otherwise stat_accepted/stat_dropped are tied to zero.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_udp_port       accepted UDP destination port
//   s_axis_*           input frame stream (tkeep ignored, words always full)
//   m_axis_*           realigned payload stream, tuser = truncation on tlast
//   stat_accepted      frames forwarded
//   stat_dropped       frames filtered out or discarded
module eth_udp_payload_extractor_128b
  import eth_udp_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cfg_udp_port,
  input  logic [127:0]         s_axis_tdata,
  input  logic [15:0]          s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [127:0]         m_axis_tdata,
  output logic [15:0]          m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] stat_accepted,
  output logic [CNT_WIDTH-1:0] stat_dropped
);

  state_t      state_r;
  logic [15:0] rem_r;
  logic [47:0] hold_r;
  logic [15:0] ethertype_r;
  logic [7:0]  ver_ihl_r;
  logic [7:0]  proto_r;

  logic [15:0] ethertype_s;
  logic [7:0]  ver_ihl_s;
  logic [7:0]  proto_s;
  logic        pass_s;
  logic [15:0] rem_s;

  logic        can_load_s;
  logic        s_ready_s;
  logic        s_hs_s;
  logic [4:0]  take_s;
  logic [4:0]  flush_take_s;
  logic [15:0] rem_next_s;
  logic        pay_last_s;
  logic        tkeep_unused_s;

  assign tkeep_unused_s = ^s_axis_tkeep;

  eth_udp_hdr_match u_hdr_match (
    .tdata        (s_axis_tdata),
    .ethertype_q  (ethertype_r),
    .ver_ihl_q    (ver_ihl_r),
    .proto_q      (proto_r),
    .cfg_udp_port (cfg_udp_port),
    .ethertype    (ethertype_s),
    .ver_ihl      (ver_ihl_s),
    .proto        (proto_s),
    .pass         (pass_s),
    .rem          (rem_s)
  );

  // Output register slot availability and per-state input ready
  always_comb begin
    can_load_s = !m_axis_tvalid || m_axis_tready;
    case (state_r)
      PAYLOAD: s_ready_s = can_load_s;
      FLUSH:   s_ready_s = 1'b0;
      default: s_ready_s = 1'b1;
    endcase
    s_hs_s = s_axis_tvalid && s_ready_s;
  end

  assign s_axis_tready = s_ready_s;

  // Bytes consumed by the current beat and whether it ends the payload
  always_comb begin
    take_s       = (rem_r >= 16'd16) ? 5'd16 : rem_r[4:0];
    flush_take_s = (rem_r > 16'(HOLD_BYTES)) ? 5'(HOLD_BYTES) : rem_r[4:0];
    rem_next_s   = rem_r - {11'd0, take_s};
    // Last beat on exhaustion, or on input end with more bytes than hold keeps
    pay_last_s   = (rem_next_s == 16'd0) ||
                   (s_axis_tlast && (rem_next_s > 16'(HOLD_BYTES)));
  end

  // Parser FSM with registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= HDR0;
      rem_r         <= 16'd0;
      hold_r        <= 48'd0;
      ethertype_r   <= 16'd0;
      ver_ihl_r     <= 8'd0;
      proto_r       <= 8'd0;
      m_axis_tdata  <= 128'd0;
      m_axis_tkeep  <= 16'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state_r)
        HDR0: begin
          if (s_hs_s) begin
            ethertype_r <= ethertype_s;
            ver_ihl_r   <= ver_ihl_s;
            state_r     <= s_axis_tlast ? HDR0 : HDR1;
          end
        end
        HDR1: begin
          if (s_hs_s) begin
            proto_r <= proto_s;
            state_r <= s_axis_tlast ? HDR0 : HDR2;
          end
        end
        HDR2: begin
          if (s_hs_s) begin
            if (pass_s) begin
              hold_r  <= s_axis_tdata[127:8*PAY_BYTE];
              rem_r   <= rem_s;
              state_r <= s_axis_tlast ? FLUSH : PAYLOAD;
            end else begin
              state_r <= s_axis_tlast ? HDR0 : DISCARD;
            end
          end
        end
        PAYLOAD: begin
          if (s_hs_s) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {s_axis_tdata[8*PAY_BYTE-1:0], hold_r};
            m_axis_tkeep  <= keep_mask(take_s);
            m_axis_tlast  <= pay_last_s;
            m_axis_tuser  <= s_axis_tlast && (rem_next_s > 16'(HOLD_BYTES));
            rem_r         <= rem_next_s;
            hold_r        <= s_axis_tdata[127:8*PAY_BYTE];
            if (rem_next_s == 16'd0) begin
              state_r <= s_axis_tlast ? HDR0 : DISCARD;
            end else if (s_axis_tlast) begin
              state_r <= (rem_next_s > 16'(HOLD_BYTES)) ? HDR0 : FLUSH;
            end
          end
        end
        FLUSH: begin
          if (can_load_s) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {80'd0, hold_r};
            m_axis_tkeep  <= keep_mask(flush_take_s);
            m_axis_tlast  <= 1'b1;
            // Only reachable with rem > hold when the frame ended on word 2
            m_axis_tuser  <= (rem_r > 16'(HOLD_BYTES));
            state_r       <= HDR0;
          end
        end
        DISCARD: begin
          if (s_hs_s && s_axis_tlast) begin
            state_r <= HDR0;
          end
        end
        default: state_r <= HDR0;
      endcase
    end
  end

`ifdef ETH_UDP_EXTRACTOR_STATS_EN
  logic                 acc_inc_s;
  logic                 drop_inc_s;
  logic [CNT_WIDTH-1:0] acc_cnt_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;

  // Frame-level accept/drop events seen this cycle
  always_comb begin
    acc_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    case (state_r)
      HDR0, HDR1: drop_inc_s = s_hs_s && s_axis_tlast;
      HDR2:       drop_inc_s = s_hs_s && !pass_s;
      PAYLOAD:    acc_inc_s  = s_hs_s && pay_last_s;
      FLUSH:      acc_inc_s  = can_load_s;
      default: begin
        acc_inc_s  = 1'b0;
        drop_inc_s = 1'b0;
      end
    endcase
  end

  // Wrapping statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (acc_inc_s) begin
        acc_cnt_r <= acc_cnt_r + CNT_WIDTH'(1);
      end
      if (drop_inc_s) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_accepted = acc_cnt_r;
  assign stat_dropped  = drop_cnt_r;
`else
  assign stat_accepted = '0;
  assign stat_dropped  = '0;
`endif

endmodule

// File: tb/tb_eth_udp_payload_extractor_128b.sv
// Directed self-checking bench for eth_udp_payload_extractor_128b.
module tb_eth_udp_payload_extractor_128b;

`ifdef ETH_UDP_EXTRACTOR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [15:0]  cfg_udp_port;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic [31:0]  stat_accepted;
  logic [31:0]  stat_dropped;

  eth_udp_payload_extractor_128b #(.CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_udp_port  (cfg_udp_port),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  beat_t      got_q[$];
  logic [7:0] frame_b [0:255];
  int         nwords;
  int         checks = 0;
  int         errors = 0;
  int         stall_cnt = 0;
  int         exp_acc = 0;
  int         exp_drop = 0;
  bit         tog_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output ready: always 1, or toggling every cycle when tog_en is set
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = tog_en ? ~m_axis_tready : 1'b1;
    end
  end

  // Capture output beats that will transfer at the next rising edge
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready)
      got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
    if (s_axis_tvalid && !s_axis_tready)
      stall_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame: filler header, given fields, payload byte k = seed + k from byte 42 on
  task automatic build(input logic [15:0] et, input logic [15:0] dp, input logic [15:0] ul,
                       input int total, input logic [7:0] seed);
    for (int i = 0; i < 256; i++)
      frame_b[i] = (i >= 42) ? seed + 8'(i - 42) : 8'h5A;
    frame_b[12] = et[15:8];
    frame_b[13] = et[7:0];
    frame_b[14] = 8'h45;
    frame_b[23] = 8'h11;
    frame_b[36] = dp[15:8];
    frame_b[37] = dp[7:0];
    frame_b[38] = ul[15:8];
    frame_b[39] = ul[7:0];
    nwords = total / 16;
  endtask

  task automatic send(input int first, input int last);
    for (int w = first; w <= last; w++) begin
      int waited = 0;
      for (int j = 0; j < 16; j++)
        s_axis_tdata[8*j +: 8] = frame_b[16*w + j];
      s_axis_tlast  = (w == nwords - 1);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 200)
        chk("send_timeout", 128'(waited), 128'd0);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Pop one frame's beats (up to tlast) and compare against expectations
  task automatic check_stream(input string tag, input int exp_beats, input logic [15:0] exp_keep,
                              input logic exp_user, input int exp_bytes, input logic [7:0] seed);
    beat_t      b;
    int         nb = 0;
    int         nbytes = 0;
    bit         ok = 1'b1;
    bit         done = 1'b0;
    logic [15:0] lk = 16'h0;
    logic       ll = 1'b0;
    logic       lu = 1'b0;
    while (!done && got_q.size() > 0) begin
      b = got_q.pop_front();
      nb++;
      for (int j = 0; j < 16; j++) begin
        if (b.k[j]) begin
          if (b.d[8*j +: 8] !== seed + 8'(nbytes)) ok = 1'b0;
          nbytes++;
        end
      end
      if ((b.k & (b.k + 16'h1)) != 16'h0) ok = 1'b0;
      lk = b.k;
      ll = b.l;
      lu = b.u;
      if (b.l) done = 1'b1;
      else if (b.k != 16'hFFFF || b.u) ok = 1'b0;
    end
    chk({tag, "_beats"}, 128'(nb), 128'(exp_beats));
    chk({tag, "_last_keep"}, 128'(lk), 128'(exp_keep));
    chk({tag, "_tlast"}, 128'(ll), 128'd1);
    chk({tag, "_tuser"}, 128'(lu), 128'(exp_user));
    chk({tag, "_bytes"}, 128'(nbytes), 128'(exp_bytes));
    chk({tag, "_order"}, 128'(ok), 128'd1);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_stat_accepted"}, 128'(stat_accepted), 128'(STATS_ON ? exp_acc : 0));
    chk({tag, "_stat_dropped"}, 128'(stat_dropped), 128'(STATS_ON ? exp_drop : 0));
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_udp_port  = 16'h1234;
    s_axis_tdata  = 128'd0;
    s_axis_tkeep  = 16'hFFFF;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tdata", m_axis_tdata, 128'd0);
    chk("rst_ctrl", 128'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 128'd0);
    chk("rst_s_tready", 128'(s_axis_tready), 128'd1);
    check_stats("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 64-byte payload in 7 words: four full beats, tlast on the fourth
    build(16'h0800, 16'h1234, 16'd72, 112, 8'h10);
    send(0, nwords - 1);
    drain();
    check_stream("t1", 4, 16'hFFFF, 1'b0, 64, 8'h10);
    exp_acc = 1;
    check_stats("t1");

    // 10-byte payload in a padded 80-byte frame: one beat, padding dropped
    stall_cnt = 0;
    build(16'h0800, 16'h1234, 16'd18, 80, 8'h40);
    send(0, nwords - 1);
    drain();
    chk("t2_no_stall", 128'(stall_cnt), 128'd0);
    check_stream("t2", 1, 16'h03FF, 1'b0, 10, 8'h40);
    exp_acc = 2;

    // 6-byte payload ending on word 2: FLUSH beat with input stalled
    build(16'h0800, 16'h1234, 16'd14, 48, 8'h70);
    send(0, nwords - 1);
    chk("t3_flush_tready", 128'(s_axis_tready), 128'd0);
    drain();
    check_stream("t3", 1, 16'h003F, 1'b0, 6, 8'h70);
    exp_acc = 3;

    // Wrong port and wrong ethertype are dropped; next valid frame intact
    build(16'h0800, 16'h1235, 16'd18, 80, 8'h20);
    send(0, nwords - 1);
    build(16'h86DD, 16'h1234, 16'd18, 80, 8'h30);
    send(0, nwords - 1);
    drain();
    chk("t4_no_beats", 128'(got_q.size()), 128'd0);
    exp_drop = 2;
    check_stats("t4");
    build(16'h0800, 16'h1234, 16'd18, 80, 8'h90);
    send(0, nwords - 1);
    drain();
    check_stream("t4v", 1, 16'h03FF, 1'b0, 10, 8'h90);
    exp_acc = 4;

    // UDP length claims 200 bytes, frame has 5 words: truncated
    build(16'h0800, 16'h1234, 16'd208, 80, 8'hC0);
    send(0, nwords - 1);
    drain();
    check_stream("t5", 2, 16'hFFFF, 1'b1, 32, 8'hC0);
    exp_acc = 5;

    // Back-to-back frames with output ready toggling
    tog_en = 1'b1;
    build(16'h0800, 16'h1234, 16'd72, 112, 8'hA0);
    send(0, nwords - 1);
    build(16'h0800, 16'h1234, 16'd18, 80, 8'hB0);
    send(0, nwords - 1);
    drain();
    check_stream("t6a", 4, 16'hFFFF, 1'b0, 64, 8'hA0);
    check_stream("t6b", 1, 16'h03FF, 1'b0, 10, 8'hB0);
    exp_acc = 7;
    check_stats("t6");

    // Reset pulsed mid-payload, then a fresh frame parses from HDR0
    build(16'h0800, 16'h1234, 16'd72, 112, 8'hD0);
    send(0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("mid_rst_tdata", m_axis_tdata, 128'd0);
    chk("mid_rst_ctrl", 128'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 128'd0);
    got_q.delete();
    exp_acc  = 0;
    exp_drop = 0;
    check_stats("mid_rst");
    tog_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    build(16'h0800, 16'h1234, 16'd18, 80, 8'hE0);
    send(0, nwords - 1);
    drain();
    check_stream("t7", 1, 16'h03FF, 1'b0, 10, 8'hE0);
    exp_acc = 1;
    check_stats("t7");
    chk("t7_queue_empty", 128'(got_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_udp_payload_extractor_128b.md
Name: eth_udp_payload_extractor_128b

Overview:
- Sits directly downstream of the 128-bit Ethernet FCS checker. Input frames are FCS-stripped, whole 16-byte words, with byte 0 in tdata[7:0].
- Parses the Ethernet + IPv4 + UDP header (42 bytes) and drops frames that fail the filter.
- Forwards the UDP payload realigned to byte 0, trimmed to the UDP length field so Ethernet padding is removed, with exact tkeep on the last word.

Parameters:
- CNT_WIDTH, 32, width of the optional statistics counters.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_udp_port  in  16  accepted UDP destination port; sampled when header word 2 is accepted
- s_axis_tdata  in  128  input data
- s_axis_tkeep  in  16  ignored; input words are always full
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input frame end
- m_axis_tdata  out  128  payload, realigned
- m_axis_tkeep  out  16  contiguous low-aligned byte mask
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  payload end
- m_axis_tuser  out  1  truncation error; valid on the tlast beat
- stat_accepted  out  CNT_WIDTH  frames forwarded
- stat_dropped  out  CNT_WIDTH  frames filtered out or discarded

Behaviour:
- Reset (rst_n low, asynchronous): state=HDR0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tuser=0; m_axis_tkeep=0; m_axis_tdata=0; counters=0; hold register=0.
- Header byte offsets:
  - ethertype: bytes 12-13, big-endian
  - IPv4 version/IHL: byte 14
  - IP protocol: byte 23
  - UDP destination port: bytes 36-37
  - UDP length: bytes 38-39
  - payload starts at byte 42, i.e. byte 10 of word 2
- Pass condition: ethertype==0x0800, byte14==0x45, protocol==0x11, dport==cfg_udp_port, 9<=udp_len.
  - Payload byte count: rem = udp_len-8, 16-bit.
- States:
  - HDR0: accept word 0; latch fields; go to HDR1.
  - HDR1: accept word 1; latch fields; go to HDR2.
  - HDR2: accept word 2 and evaluate pass.
    - pass: load hold=word2[127:80] and rem; go to PAYLOAD.
    - fail: stat_dropped++; go to DISCARD, or to HDR0 if tlast is on this beat.
  - PAYLOAD: on each accepted input word w, present {w[79:0], hold} with tkeep = mask(min(rem,16)); then rem -= min(rem,16) and hold=w[127:80].
    - rem becomes 0 and !tlast: output tlast=1; go to DISCARD.
    - rem becomes 0 and tlast: output tlast=1; go to HDR0.
    - tlast, 0<rem'<=6: go to FLUSH.
    - tlast, rem'>6: output tlast=1, tuser=1 (truncated); go to HDR0.
  - FLUSH: s_axis_tready=0; emit {80'h0, hold} with tkeep=mask(rem), tlast=1; go to HDR0.
  - DISCARD: accept and drop words until tlast; then go to HDR0.
- stat_accepted increments when each tlast output beat is loaded, whether or not tuser is set. stat_dropped counts filter failures and frames whose tlast arrives in HDR0 or HDR1.
- tlast arriving in HDR0 or HDR1: frame is dropped and the state returns to HDR0.
- Payload that fits entirely in word 2 (rem<=6) still waits for word 3; if tlast arrives on word 2, go to FLUSH.
- Handshake:
  - Single output register. s_axis_tready = !m_axis_tvalid || m_axis_tready in PAYLOAD.
  - In HDR0, HDR1, HDR2 and DISCARD, s_axis_tready=1.
  - In FLUSH, s_axis_tready=0.
  - Output fields are held stable while tvalid && !tready.
- Latency: first payload beat is valid 1 cycle after word 3 is accepted.
- Throughput: 1 word per cycle. FLUSH costs one bubble per frame.

Optional Feature:
- Macro ETH_UDP_EXTRACTOR_STATS_EN.
- Defined: stat_accepted and stat_dropped count as specified and wrap at 2^CNT_WIDTH.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package eth_udp_pkg:
  - byte-offset localparams for ethertype, IHL, protocol, dport and ulen
  - ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, HDR_BYTES=42
  - state enum typedef {HDR0,HDR1,HDR2,PAYLOAD,FLUSH,DISCARD}
  - function keep_mask(count) returning 16-bit
- One sub-module: eth_udp_hdr_match, combinational field extraction and pass decision from words 0-2.

Test Plan:
- Valid UDP to port 0x1234, udp_len=8+64, 7 input words (no padding) -> 4 full beats with payload bytes in order plus one 6-byte FLUSH beat? No: 64 = 6+58; expect beats tkeep FFFF×4, tlast on 4th, no FLUSH; stat_accepted=1.
- udp_len=8+10 in a 64-byte padded frame -> one beat, tkeep=03FF, tlast=1, padding words discarded, s_axis_tready stays 1.
- Payload of 6 bytes with tlast on word 2 -> FLUSH beat tkeep=003F, tlast=1; tready=0 for that cycle.
- Wrong port 0x1235 or ethertype 0x86DD -> no output beats, stat_dropped=1, following valid frame forwarded intact.
- udp_len claims 200 bytes but frame has 5 words -> last beat tlast=1, tuser=1.
- m_axis_tready toggling 50% with back-to-back frames, plus rst_n pulsed mid-payload -> no data loss or duplication; after reset outputs are 0 and the next frame parses from HDR0.
